inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch initiator for the five-stage MIPS32 pipeline. It owns the program counter and drives the chip-enable/address side of the instruction ROM. It samples the ROM's same-cycle combinational instruction and registers it, with its PC, into the IF/ID pipeline register for the decode stage. It applies pipeline-control stalls, exception flushes and delayed-slot branch redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports (reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable`).
- stall_if  in  1  from ctrl; hold the PC.
- stall_id  in  1  from ctrl; hold IF/ID.
- flush  in  1  exception/eret flush from ctrl.
- flush_pc  in  32  handler/EPC address, used when flush=1.
- branch_flag  in  1  from ID; taken branch/jump.
- branch_target  in  32  redirect address.
- rom_ce  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- rom_addr  out  32  byte address to ROM; equals the PC register.
- rom_inst  in  32  combinational ROM data for rom_addr.
- id_pc  out  32  PC of the instruction held in IF/ID.
- id_inst  out  32  instruction held in IF/ID; `ZEROWORD` means bubble.
- id_valid  out  1  IF/ID holds a real fetch.
- id_adel  out  1  fetch address error (see Configuration).

## Operation
- Reset values: rom_ce=0, PC=RESET_PC, id_pc=0, id_inst=0, id_valid=0, id_adel=0.
- rom_ce is a register. It is 0 during reset and becomes 1 at the first edge with rst=0. The PC holds RESET_PC while rom_ce=0, so the first address presented with rom_ce=1 is RESET_PC.
- PC next-state priority is rst > flush > stall_if > branch_flag > PC+4:
  - flush: load flush_pc.
  - stall_if: hold.
  - branch_flag: load branch_target.
  - otherwise: load PC+4.
- PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID next-state priority is rst > flush > stall_id > stall_if > normal:
  - rst or flush: load a bubble (pc=0, inst=0, valid=0, adel=0).
  - stall_id: hold all fields.
  - stall_if with stall_id=0: insert a bubble.
  - rom_ce=0: insert a bubble.
  - normal: load id_pc=PC, id_inst=rom_inst, id_valid=1.
- Delay slot: when branch_flag is asserted, the instruction fetched in that same cycle is the architectural delay slot. It is captured normally and is never squashed by a branch. Only flush squashes it.
- Simultaneous flush and stall: flush wins on both the PC and IF/ID.
- Simultaneous branch_flag and stall_if: the PC holds and the branch is lost. Ctrl must keep branch_flag asserted until the stall is released. The ID stage does this naturally, because a stalled ID holds its instruction.
- A reset asserted mid-operation returns all state to the reset values on the next edge, with no partial update.

## Timing
- Single clock domain. There are no combinational paths from inputs to rom_addr/rom_ce; both are direct register outputs.
- ROM read completes in 0 cycles. The fetch-to-decode latency is 1 cycle: the instruction at rom_addr in cycle N appears on id_inst in cycle N+1.
- Branch penalty is 0 cycles beyond the delay slot: branch_flag in cycle N puts rom_addr=branch_target in cycle N+1.
- After rst deasserts, cycle 0 has rom_ce=0. Cycle 1 has rom_ce=1 and rom_addr=RESET_PC. Cycle 2 has id_valid=1 with id_pc=RESET_PC.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - When PC[1:0]≠0 and rom_ce=1, IF/ID loads id_inst=0, id_valid=1, id_adel=1 and id_pc=PC, for the exception unit to raise AdEL.
  - PC sequencing is otherwise unchanged.
- FETCH_ALIGN_CHECK_EN undefined:
  - id_adel is tied to 0.
  - Low address bits are passed through unchecked; the ROM word-indexes by addr>>2.

## Structure
- Shared defines header holds `InstAddrBus`, `InstBus`, `ZEROWORD`, `ChipEnable`/`ChipDisable`, `RstEnable` and `StallEnable`. The reset-PC constant is added there as well.
- Sub-module if_id_reg implements the IF/ID register, with its bubble/hold/flush logic and the adel field.
- inst_fetch holds the PC, the ce register and the next-PC mux, and instantiates if_id_reg.

## Test plan
- Reset release → rom_ce 0 for 1 cycle, then rom_addr 0x0, 0x4, 0x8. id_inst equals ROM words 0, 1, 2 one cycle later, with id_valid=1.
- branch_flag=1 with branch_target=0x40 while PC=0x8 → ID receives 0x8 (delay slot), then 0x40, 0x44.
- stall_if=stall_id=1 for 3 cycles at PC=0x10 → rom_addr holds 0x10 and IF/ID holds. With stall_if=1, stall_id=0 → one bubble (inst=0, valid=0).
- flush=1 with flush_pc=0x180 during a stall → next rom_addr=0x180 and IF/ID bubble. Fetch resumes at 0x184.
- PC=0xFFFF_FFFC with no events → next rom_addr=0x0.
- With FETCH_ALIGN_CHECK_EN, branch_target=0x42 → id_adel=1, id_pc=0x42, id_inst=0. Without the macro → id_adel=0 and id_inst=ROM word 0x10.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned fetch -> AdEL marker in IF/ID).
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZEROWORD         = '0;
  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       CHIP_DISABLE     = 1'b0;
  localparam logic       RST_ENABLE       = 1'b1;
  localparam logic       STALL_ENABLE     = 1'b1;
  localparam inst_addr_t DEFAULT_RESET_PC = 32'h0000_0000;

  // One IF/ID pipeline entry.
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    logic       valid;
    logic       adel;
  } if_id_t;

  // An empty slot: decode treats a zero instruction with valid=0 as a bubble.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc    = '0;
    b.inst  = ZEROWORD;
    b.valid = 1'b0;
    b.adel  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction ROM bus: fetch stage drives chip enable and address, ROM returns
// the addressed word combinationally in the same cycle.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_inst;

  modport master (output rom_ce, output rom_addr, input rom_inst);
  modport slave  (input rom_ce, input rom_addr, output rom_inst);

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: bubble insertion, hold on decode stall, flush.
// With FETCH_ALIGN_CHECK_EN defined, a misaligned fetch is captured as a
// zero instruction flagged with adel so the exception unit can raise AdEL.
module if_id_reg
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall_if,
  input  logic       stall_id,
  input  logic       fetch_ce,
  input  inst_addr_t fetch_pc,
  input  inst_t      fetch_inst,
  output inst_addr_t id_pc,
  output inst_t      id_inst,
  output logic       id_valid,
  output logic       id_adel
);

  if_id_t ent_d;
  if_id_t ent_q;

  // Next IF/ID entry: flush > decode hold > fetch stall bubble > idle bubble > capture.
  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = if_id_bubble();
    end else if (stall_id == STALL_ENABLE) begin
      ent_d = ent_q;
    end else if (stall_if == STALL_ENABLE) begin
      ent_d = if_id_bubble();
    end else if (fetch_ce == CHIP_DISABLE) begin
      ent_d = if_id_bubble();
    end else begin
      ent_d.pc    = fetch_pc;
      ent_d.valid = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (fetch_pc[1:0] != 2'b00) begin
        ent_d.inst = ZEROWORD;
        ent_d.adel = 1'b1;
      end else begin
        ent_d.inst = fetch_inst;
        ent_d.adel = 1'b0;
      end
`else
      ent_d.inst  = fetch_inst;
      ent_d.adel  = 1'b0;
`endif
    end
  end

  // IF/ID register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ent_q <= if_id_bubble();
    end else begin
      ent_q <= ent_d;
    end
  end

  assign id_pc    = ent_q.pc;
  assign id_inst  = ent_q.inst;
  assign id_valid = ent_q.valid;
  assign id_adel  = ent_q.adel;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: program counter, ROM chip enable and next-PC selection,
// feeding the IF/ID register. Branches use a delay slot, so the instruction
// fetched alongside branch_flag is always captured.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (handled in if_id_reg).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_if,
  input  logic                stall_id,
  input  logic                flush,
  input  inst_addr_t          flush_pc,
  input  logic                branch_flag,
  input  inst_addr_t          branch_target,
  inst_fetch_if.master        rom,
  output inst_addr_t          id_pc,
  output inst_t               id_inst,
  output logic                id_valid,
  output logic                id_adel
);

  logic       ce_d;
  logic       ce_q;
  inst_addr_t pc_d;
  inst_addr_t pc_q;

  // Next PC: hold until the ROM is enabled, then flush > stall > branch > sequential.
  always_comb begin
    ce_d = CHIP_ENABLE;
    pc_d = pc_q + 32'd4;
    if (ce_q == CHIP_DISABLE) begin
      pc_d = pc_q;
    end else if (flush) begin
      pc_d = flush_pc;
    end else if (stall_if == STALL_ENABLE) begin
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = branch_target;
    end
  end

  // PC and chip-enable registers; both drive the ROM directly.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ce_q <= CHIP_DISABLE;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= ce_d;
      pc_q <= pc_d;
    end
  end

  assign rom.rom_ce   = ce_q;
  assign rom.rom_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .fetch_ce   (ce_q),
    .fetch_pc   (pc_q),
    .fetch_inst (rom.rom_inst),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .id_adel    (id_adel)
  );

endmodule
